// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and helpers for the truth-table sweeper
package tt_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  // Row 000 lands in the most significant bit of the code.
  localparam bit TT_MSB_FIRST = 1'b1;

  function automatic int unsigned tt_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control/result bundle between requester and sweeper
interface truth_table_sweeper_if #(
  parameter int unsigned TT_W = 8
);
  logic            start;
  logic [TT_W-1:0] expected;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] tt_code;
  logic            match;

  modport master (output start, expected, input busy, done, tt_code, match);
  modport slave  (input start, expected, output busy, done, tt_code, match);
endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - per-row settle down-counter; expire marks the last settle cycle
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = (cnt == 8'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input rows of a gate and assembles its truth-table code
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  ctl,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out
);

  localparam int unsigned TT_W = tt_w(N_IN);

  state_e            state;
  logic [N_IN-1:0]   idx;
  logic [N_IN-1:0]   bitpos;
  logic [TT_W-1:0]   expected_q;
  logic [TT_W-1:0]   code_next;
  logic              last_row;
  logic              enter_settle;
  logic              expire;

  assign last_row     = (idx == N_IN'(TT_W - 1));
  assign bitpos       = TT_MSB_FIRST ? (N_IN'(TT_W - 1) - idx) : idx;
  assign enter_settle = (state == IDLE && ctl.start) || (state == SAMPLE && !last_row);

  always_comb begin
    code_next         = ctl.tt_code;
    code_next[bitpos] = dut_out;
  end

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (enter_settle),
    .en     (state == SETTLE),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      dut_in      <= '0;
      expected_q  <= '0;
      ctl.tt_code <= '0;
      ctl.match   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl.start) begin
            expected_q  <= ctl.expected;
            ctl.tt_code <= '0;
            ctl.match   <= 1'b0;
            idx         <= '0;
            dut_in      <= '0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (expire) state <= SAMPLE;
        end
        SAMPLE: begin
          ctl.tt_code <= code_next;
          if (last_row) begin
            // Compare against the completed code so match is valid while done is high.
            ctl.match <= (code_next == expected_q);
            state     <= DONE;
          end else begin
            idx    <= idx + N_IN'(1);
            dut_in <= idx + N_IN'(1);
            state  <= SETTLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.busy = (state != IDLE);
  assign ctl.done = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: SETTLE_CYCLES=4, 1: SETTLE_CYCLES=1, 2: SETTLE_CYCLES=2 with delayed gate
  logic       start_v    [3];
  logic [7:0] expected_v [3];
  logic       busy_v     [3];
  logic       done_v     [3];
  logic       match_v    [3];
  logic [7:0] tt_v       [3];
  logic [2:0] din_v      [3];

  int   gsel   = 0;
  logic gdelay = 1'b0;

  logic [2:0] din_a, din_b, din_c;
  logic       dout_a, dout_b, dout_c;
  logic [2:0] da1, da2, da3, dc1, dc2, dc3;

  truth_table_sweeper_if #(.TT_W(8)) ifa ();
  truth_table_sweeper_if #(.TT_W(8)) ifb ();
  truth_table_sweeper_if #(.TT_W(8)) ifc ();

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctl(ifa), .dut_in(din_a), .dut_out(dout_a));
  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctl(ifb), .dut_in(din_b), .dut_out(dout_b));
  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .ctl(ifc), .dut_in(din_c), .dut_out(dout_c));

  assign ifa.start = start_v[0];  assign ifa.expected = expected_v[0];
  assign ifb.start = start_v[1];  assign ifb.expected = expected_v[1];
  assign ifc.start = start_v[2];  assign ifc.expected = expected_v[2];

  assign busy_v[0] = ifa.busy;  assign done_v[0] = ifa.done;  assign match_v[0] = ifa.match;
  assign busy_v[1] = ifb.busy;  assign done_v[1] = ifb.done;  assign match_v[1] = ifb.match;
  assign busy_v[2] = ifc.busy;  assign done_v[2] = ifc.done;  assign match_v[2] = ifc.match;
  assign tt_v[0] = ifa.tt_code; assign tt_v[1] = ifb.tt_code; assign tt_v[2] = ifc.tt_code;
  assign din_v[0] = din_a;      assign din_v[1] = din_b;      assign din_v[2] = din_c;

  // Gate models: 0 = reference function (code 4D), 1 = const 0, 2 = in1&in2&in3, 3 = in1
  function automatic logic gut_f(input int sel, input logic [2:0] in);
    case (sel)
      1:       return 1'b0;
      2:       return in[2] & in[1] & in[0];
      3:       return in[2];
      default: return (in == 3'd1) || (in == 3'd4) || (in == 3'd5) || (in == 3'd7);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      da1 <= '0; da2 <= '0; da3 <= '0;
      dc1 <= '0; dc2 <= '0; dc3 <= '0;
    end else begin
      da1 <= din_a; da2 <= da1; da3 <= da2;
      dc1 <= din_c; dc2 <= dc1; dc3 <= dc2;
    end
  end

  assign dout_a = gdelay ? gut_f(gsel, da3) : gut_f(gsel, din_a);
  assign dout_b = gut_f(0, din_b);
  assign dout_c = gut_f(0, dc3);

  logic [2:0] q_b [$];
  always @(negedge clk) begin
    if (ifb.busy && !ifb.done) q_b.push_back(din_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns the cycle count from the start cycle to the done cycle (-1 on timeout or reset).
  task automatic sweep(input int w, input logic [7:0] exp, input int pulse_at,
                       input int rst_at, output int lat);
    lat = -1;
    @(negedge clk);
    start_v[w]    = 1'b1;
    expected_v[w] = exp;
    @(negedge clk);
    start_v[w] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (rst_at > 0 && c == rst_at + 1) begin
        rst_n = 1'b1;
        check("rst_busy",  busy_v[w],  0);
        check("rst_dutin", din_v[w],   0);
        check("rst_code",  tt_v[w],    0);
        check("rst_match", match_v[w], 0);
        return;
      end
      if (done_v[w]) begin
        lat = c;
        return;
      end
      start_v[w] = (c == pulse_at);
      rst_n      = !(c == rst_at);
      @(negedge clk);
    end
    check("timeout", 1, 0);
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i]    = 1'b0;
      expected_v[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_busy",  ifa.busy,  0);
    check("reset_done",  ifa.done,  0);
    check("reset_code",  ifa.tt_code, 0);
    check("reset_match", ifa.match, 0);
    check("reset_dutin", din_a,     0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    gsel = 0;
    sweep(0, 8'h4D, -1, -1, lat);
    check("t1_latency", lat, 41);
    check("t1_code",    ifa.tt_code, 8'h4D);
    check("t1_match",   ifa.match, 1);
    check("t1_busy",    ifa.busy, 1);
    @(negedge clk);
    check("t1_done_pulse", ifa.done, 0);
    check("t1_busy_drop",  ifa.busy, 0);
    check("t1_code_hold",  ifa.tt_code, 8'h4D);

    gsel = 1;
    sweep(0, 8'h00, -1, -1, lat);
    check("t2_zero_code",  ifa.tt_code, 8'h00);
    check("t2_zero_match", ifa.match, 1);
    gsel = 2;
    sweep(0, 8'h01, -1, -1, lat);
    check("t2_and_code",  ifa.tt_code, 8'h01);
    check("t2_and_match", ifa.match, 1);

    gsel = 3;
    sweep(0, 8'hF0, -1, -1, lat);
    check("t3_code",  ifa.tt_code, 8'h0F);
    check("t3_match", ifa.match, 0);
    check("t3_done",  ifa.done, 1);
    repeat (5) @(negedge clk);
    check("t3_code_hold",  ifa.tt_code, 8'h0F);
    check("t3_match_hold", ifa.match, 0);

    gsel = 0;
    sweep(0, 8'h4D, 17, -1, lat);
    check("t4_restart_latency", lat, 41);
    check("t4_restart_code",    ifa.tt_code, 8'h4D);
    check("t4_restart_match",   ifa.match, 1);
    sweep(0, 8'h4D, -1, 27, lat);
    repeat (2) @(negedge clk);

    q_b.delete();
    sweep(1, 8'h4D, -1, -1, lat);
    check("t5_latency", lat, 17);
    check("t5_code",    ifb.tt_code, 8'h4D);
    check("t5_match",   ifb.match, 1);
    check("t5_rows",    q_b.size(), 16);
    for (int i = 0; i < 16 && i < q_b.size(); i++)
      check($sformatf("t5_dutin_%0d", i), q_b[i], i / 2);

    gdelay = 1'b1;
    gsel   = 0;
    sweep(0, 8'h4D, -1, -1, lat);
    check("t6_slow_s4_code",  ifa.tt_code, 8'h4D);
    check("t6_slow_s4_match", ifa.match, 1);
    // With only two settle cycles each row captures the previous row's value.
    sweep(2, 8'h4D, -1, -1, lat);
    check("t6_slow_s2_latency", lat, 25);
    check("t6_slow_s2_code",    ifc.tt_code, 8'h26);
    check("t6_slow_s2_match",   ifc.match, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
